proj_sub: RTL and testbench

//  Gram-Schmidt residual stage directly downstream of mul_dot. Latches one 3-element column a_k,

---
 rtl/qr_pkg.sv | 29 ++
 rtl/proj_sub_lane.sv | 68 ++++++
 rtl/proj_sub.sv | 146 ++++++++++++++
 tb/tb_proj_sub.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qr_pkg.sv
// Shared constants, FSM state type and helpers for the QR residual stage.
// Fixed-point widths follow the mul_dot -> proj_sub -> normalise chain.
package qr_pkg;

    localparam int DATA_W    = 16;
    localparam int PROD_W    = 32;
    localparam int FRAC_BITS = 8;
    localparam int MAX_PROJ  = 3;
    localparam int GUARD     = 3;
    localparam int ACC_W     = DATA_W + GUARD;
    localparam int CNT_W     = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } proj_state_e;

    // Requested projection count limited to the matrix size.
    function automatic logic [CNT_W-1:0] clamp_cnt(
        input logic [CNT_W-1:0] n
    );
        if (int'(n) > MAX_PROJ) begin
            return CNT_W'(MAX_PROJ);
        end
        return n;
    endfunction

endpackage

// File: rtl/proj_sub_lane.sv
// One residual lane: accumulator, projection alignment, subtract, saturate.
// Ports: clk, reset; load/sub/fin_a/fin_s enables; a, d in; v, sat out.
module proj_sub_lane
    import qr_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              sub,
    input  logic              fin_a,
    input  logic              fin_s,
    input  logic [DATA_W-1:0] a,
    input  logic [PROD_W-1:0] d,
    output logic [DATA_W-1:0] v,
    output logic              sat
);

    localparam logic signed [ACC_W-1:0] V_MAX =
        ACC_W'(2 ** (DATA_W - 1) - 1);
    localparam logic signed [ACC_W-1:0] V_MIN =
        ACC_W'(-(2 ** (DATA_W - 1)));

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] aligned;
    logic signed [ACC_W-1:0] diff;
    logic        [DATA_W-1:0] clip;
    logic                     clipped;
    logic                     unused_bits;

    // Drop the extra product fraction; bits above ACC_W are discarded.
    assign aligned = $signed(d[FRAC_BITS +: ACC_W]);
    assign diff    = acc - aligned;
    assign unused_bits = ^{d[PROD_W-1:FRAC_BITS+ACC_W], d[FRAC_BITS-1:0]};

    always_comb begin
        clip    = diff[DATA_W-1:0];
        clipped = 1'b0;
        if (diff > V_MAX) begin
            clip    = {1'b0, {(DATA_W-1){1'b1}}};
            clipped = 1'b1;
        end else if (diff < V_MIN) begin
            clip    = {1'b1, {(DATA_W-1){1'b0}}};
            clipped = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc <= '0;
            v   <= '0;
            sat <= 1'b0;
        end else begin
            if (load) begin
                acc <= ACC_W'($signed(a));
            end else if (sub) begin
                acc <= diff;
            end
            if (fin_a) begin
                v   <= a;
                sat <= 1'b0;
            end else if (fin_s) begin
                v   <= clip;
                sat <= clipped;
            end
        end
    end

endmodule

// File: rtl/proj_sub.sv
// Gram-Schmidt residual stage: v_k = a_k - sum of projections from mul_dot.
// Ports: start/a*/num_proj load a column, proj_valid/d*_mul subtract,
// ready/busy/stop status, v*/sat result, extra flags stray projections.
module proj_sub
    import qr_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] a1,
    input  logic [DATA_W-1:0] a2,
    input  logic [DATA_W-1:0] a3,
    input  logic [1:0]        num_proj,
    input  logic              proj_valid,
    input  logic [PROD_W-1:0] d1_mul,
    input  logic [PROD_W-1:0] d2_mul,
    input  logic [PROD_W-1:0] d3_mul,
    output logic              ready,
    output logic              busy,
    output logic [DATA_W-1:0] v1,
    output logic [DATA_W-1:0] v2,
    output logic [DATA_W-1:0] v3,
    output logic              stop,
    output logic              sat,
    output logic              extra
);

    proj_state_e      state;
    proj_state_e      state_n;
    logic [CNT_W-1:0] cnt;
    logic             load;
    logic             sub;
    logic             fin_a;
    logic             fin_s;
    logic             s1;
    logic             s2;
    logic             s3;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        load    = 1'b0;
        sub     = 1'b0;
        fin_a   = 1'b0;
        fin_s   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    load = 1'b1;
                    if (clamp_cnt(num_proj) == '0) begin
                        fin_a   = 1'b1;
                        state_n = DONE;
                    end else begin
                        state_n = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (proj_valid) begin
                    sub = 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        fin_s   = 1'b1;
                        state_n = DONE;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            extra <= 1'b0;
        end else begin
            if (load) begin
                cnt <= clamp_cnt(num_proj);
            end else if (sub) begin
                cnt <= cnt - CNT_W'(1);
            end
            // A stray projection wins over the clear from a same-cycle start.
            if (proj_valid && state != ACCUM) begin
                extra <= 1'b1;
            end else if (load) begin
                extra <= 1'b0;
            end
        end
    end

    proj_sub_lane u_lane1 (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .sub   (sub),
        .fin_a (fin_a),
        .fin_s (fin_s),
        .a     (a1),
        .d     (d1_mul),
        .v     (v1),
        .sat   (s1)
    );

    proj_sub_lane u_lane2 (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .sub   (sub),
        .fin_a (fin_a),
        .fin_s (fin_s),
        .a     (a2),
        .d     (d2_mul),
        .v     (v2),
        .sat   (s2)
    );

    proj_sub_lane u_lane3 (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .sub   (sub),
        .fin_a (fin_a),
        .fin_s (fin_s),
        .a     (a3),
        .d     (d3_mul),
        .v     (v3),
        .sat   (s3)
    );

    assign sat   = s1 | s2 | s3;
    assign ready = (state == IDLE);
    assign busy  = (state == ACCUM);
    assign stop  = (state == DONE);

endmodule

// File: tb/tb_proj_sub.sv
// Self-checking bench for proj_sub: directed cases plus randomized
// columns against an arithmetic reference model.
module tb_proj_sub;

    typedef logic [2:0][15:0]      col_t;
    typedef logic [2:0][2:0][31:0] dmat_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] a1 = '0, a2 = '0, a3 = '0;
    logic [1:0]  num_proj = '0;
    logic        proj_valid = 1'b0;
    logic [31:0] d1_mul = '0, d2_mul = '0, d3_mul = '0;
    logic        ready, busy, stop, sat, extra;
    logic [15:0] v1, v2, v3;

    int checks = 0;
    int failures = 0;
    int stop_cnt = 0;

    proj_sub dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .a1         (a1),
        .a2         (a2),
        .a3         (a3),
        .num_proj   (num_proj),
        .proj_valid (proj_valid),
        .d1_mul     (d1_mul),
        .d2_mul     (d2_mul),
        .d3_mul     (d3_mul),
        .ready      (ready),
        .busy       (busy),
        .v1         (v1),
        .v2         (v2),
        .v3         (v3),
        .stop       (stop),
        .sat        (sat),
        .extra      (extra)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (stop) stop_cnt++;

    initial begin
        #1ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // v = sat16(a - sum(d >> FRAC)), accumulator wraps at 19 bits.
    function automatic void model(input col_t a, input int n,
                                  input dmat_t d, output col_t v,
                                  output logic s);
        longint acc;
        logic [18:0] al;
        logic [18:0] w;
        s = 1'b0;
        for (int i = 0; i < 3; i++) begin
            acc = longint'($signed(a[i]));
            for (int j = 0; j < n; j++) begin
                al  = d[j][i][26:8];
                acc = acc - longint'($signed(al));
                w   = acc[18:0];
                acc = longint'($signed(w));
            end
            if (acc > 32767) begin
                v[i] = 16'h7FFF;
                s = 1'b1;
            end else if (acc < -32768) begin
                v[i] = 16'h8000;
                s = 1'b1;
            end else begin
                v[i] = acc[15:0];
            end
        end
    endfunction

    task automatic run_column(input col_t a, input int n, input dmat_t d,
                              input int gap_max, output col_t gv,
                              output logic gs, output logic t_ok,
                              output logic r_ok, output logic b_seen);
        int gaps;
        t_ok = 1'b1;
        b_seen = 1'b0;
        for (int k = 0; k < 20 && !ready; k++) tick();
        if (!ready) t_ok = 1'b0;
        a1 = a[0]; a2 = a[1]; a3 = a[2];
        num_proj = n[1:0];
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 0; j < n; j++) begin
            gaps = $urandom_range(0, gap_max);
            for (int g = 0; g < gaps; g++) begin
                if (stop) t_ok = 1'b0;
                if (busy) b_seen = 1'b1;
                tick();
            end
            if (stop) t_ok = 1'b0;
            if (busy) b_seen = 1'b1;
            d1_mul = d[j][0]; d2_mul = d[j][1]; d3_mul = d[j][2];
            proj_valid = 1'b1;
            tick();
            proj_valid = 1'b0;
        end
        if (!stop || busy) t_ok = 1'b0;
        gv = {v3, v2, v1};
        gs = sat;
        tick();
        r_ok = ready && !stop;
    endtask

    task automatic test_reset();
        checks++;
        if ({v3, v2, v1} !== 48'h0 || sat !== 1'b0 || stop !== 1'b0) begin
            failures++;
            $display("FAIL reset_out v=%h sat=%b stop=%b exp v=0 sat=0 stop=0",
                     {v3, v2, v1}, sat, stop);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (ready !== 1'b1 || busy !== 1'b0 || extra !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctl ready=%b busy=%b extra=%b exp 1 0 0",
                     ready, busy, extra);
        end
    endtask

    task automatic test_basic();
        col_t a, gv;
        dmat_t d;
        logic gs, t_ok, r_ok, b_seen;
        a = {16'hFF00, 16'h0100, 16'h0300};
        d = '0;
        d[0] = {32'h0, 32'h00008000, 32'h00010000};
        run_column(a, 1, d, 0, gv, gs, t_ok, r_ok, b_seen);
        checks++;
        if (gv !== {16'hFF00, 16'h0080, 16'h0200} || gs !== 1'b0) begin
            failures++;
            $display("FAIL basic_v got=%h sat=%b exp=ff0000800200 sat=0", gv, gs);
        end
        checks++;
        if (t_ok !== 1'b1 || r_ok !== 1'b1) begin
            failures++;
            $display("FAIL basic_timing got t=%b r=%b exp 1 1", t_ok, r_ok);
        end
    endtask

    task automatic test_back_to_back();
        col_t a, gv;
        dmat_t d;
        logic gs, t_ok, r_ok, b_seen;
        int s0;
        a = {16'h0, 16'h0, 16'h0400};
        d = '0;
        for (int j = 0; j < 3; j++) d[j][0] = 32'h00010000;
        s0 = stop_cnt;
        run_column(a, 3, d, 0, gv, gs, t_ok, r_ok, b_seen);
        checks++;
        if (gv !== {16'h0, 16'h0, 16'h0100} || gs !== 1'b0) begin
            failures++;
            $display("FAIL b2b_v got=%h sat=%b exp=000000000100 sat=0", gv, gs);
        end
        checks++;
        if (stop_cnt - s0 != 1 || t_ok !== 1'b1 || r_ok !== 1'b1) begin
            failures++;
            $display("FAIL b2b_stop got stops=%0d t=%b r=%b exp 1 1 1",
                     stop_cnt - s0, t_ok, r_ok);
        end
    endtask

    task automatic test_zero_proj();
        col_t a, gv;
        dmat_t d;
        logic gs, t_ok, r_ok, b_seen;
        a = {16'h7FFF, 16'h8000, 16'h1234};
        d = '0;
        run_column(a, 0, d, 0, gv, gs, t_ok, r_ok, b_seen);
        checks++;
        if (gv !== a || gs !== 1'b0) begin
            failures++;
            $display("FAIL zero_v got=%h sat=%b exp=%h sat=0", gv, gs, a);
        end
        checks++;
        if (t_ok !== 1'b1 || b_seen !== 1'b0 || r_ok !== 1'b1) begin
            failures++;
            $display("FAIL zero_timing got t=%b busy=%b r=%b exp 1 0 1",
                     t_ok, b_seen, r_ok);
        end
    endtask

    task automatic test_saturation();
        col_t a, gv;
        dmat_t d;
        logic gs, t_ok, r_ok, b_seen;
        a = {16'h0, 16'h0, 16'h7F00};
        d = '0;
        d[0][0] = 32'hFF000000;
        run_column(a, 1, d, 0, gv, gs, t_ok, r_ok, b_seen);
        checks++;
        if (gv[0] !== 16'h7FFF || gs !== 1'b1) begin
            failures++;
            $display("FAIL sat_pos got v1=%h sat=%b exp 7fff 1", gv[0], gs);
        end
        a = {16'h0, 16'h0, 16'h8100};
        d[0][0] = 32'h01000000;
        run_column(a, 1, d, 0, gv, gs, t_ok, r_ok, b_seen);
        checks++;
        if (gv[0] !== 16'h8000 || gs !== 1'b1) begin
            failures++;
            $display("FAIL sat_neg got v1=%h sat=%b exp 8000 1", gv[0], gs);
        end
    endtask

    task automatic test_extra();
        proj_valid = 1'b1;
        d1_mul = 32'h00050000;
        tick();
        proj_valid = 1'b0;
        checks++;
        if (extra !== 1'b1 || ready !== 1'b1) begin
            failures++;
            $display("FAIL extra_idle got extra=%b ready=%b exp 1 1", extra, ready);
        end
        a1 = 16'h0500; a2 = 16'h0; a3 = 16'h0;
        num_proj = 2'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (extra !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL extra_clear got extra=%b busy=%b exp 0 1", extra, busy);
        end
        a1 = 16'h7000;
        num_proj = 2'd0;
        start = 1'b1;
        d1_mul = 32'h00010000; d2_mul = '0; d3_mul = '0;
        proj_valid = 1'b1;
        tick();
        start = 1'b0;
        proj_valid = 1'b1;
        tick();
        proj_valid = 1'b0;
        checks++;
        if (stop !== 1'b1 || v1 !== 16'h0300 || sat !== 1'b0 || extra !== 1'b0) begin
            failures++;
            $display("FAIL extra_ignore got stop=%b v1=%h sat=%b extra=%b exp 1 0300 0 0",
                     stop, v1, sat, extra);
        end
        tick();
        a1 = 16'h0042;
        num_proj = 2'd0;
        start = 1'b1;
        proj_valid = 1'b1;
        tick();
        start = 1'b0;
        proj_valid = 1'b0;
        checks++;
        if (extra !== 1'b1 || stop !== 1'b1 || v1 !== 16'h0042) begin
            failures++;
            $display("FAIL extra_same got extra=%b stop=%b v1=%h exp 1 1 0042",
                     extra, stop, v1);
        end
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (extra !== 1'b0) begin
            failures++;
            $display("FAIL extra_next got extra=%b exp 0", extra);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        col_t a, gv;
        dmat_t d;
        logic gs, t_ok, r_ok, b_seen;
        int s0;
        a1 = 16'h0600; a2 = 16'h0; a3 = 16'h0;
        num_proj = 2'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        d1_mul = 32'h00010000; d2_mul = '0; d3_mul = '0;
        proj_valid = 1'b1;
        tick();
        proj_valid = 1'b0;
        s0 = stop_cnt;
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({v3, v2, v1} !== 48'h0 || sat !== 1'b0 || stop !== 1'b0 ||
            busy !== 1'b0 || extra !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid got v=%h sat=%b stop=%b busy=%b extra=%b exp all 0",
                     {v3, v2, v1}, sat, stop, busy, extra);
        end
        #2 reset = 1'b0;
        tick();
        tick();
        checks++;
        if (stop_cnt != s0 || ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_nostop got stops=%0d ready=%b exp 0 1",
                     stop_cnt - s0, ready);
        end
        a = {16'h0, 16'h0, 16'h0600};
        d = '0;
        d[0][0] = 32'h00010000;
        d[1][0] = 32'h00010000;
        run_column(a, 2, d, 1, gv, gs, t_ok, r_ok, b_seen);
        checks++;
        if (gv !== {16'h0, 16'h0, 16'h0400} || t_ok !== 1'b1) begin
            failures++;
            $display("FAIL rst_fresh got v=%h t=%b exp 000000000400 1", gv, t_ok);
        end
    endtask

    task automatic test_random();
        col_t a, gv, ev;
        dmat_t d;
        logic gs, es, t_ok, r_ok, b_seen;
        int n;
        int sv;
        for (int it = 0; it < 60; it++) begin
            n = $urandom_range(0, 3);
            for (int i = 0; i < 3; i++) begin
                a[i] = 16'($urandom);
                for (int j = 0; j < 3; j++) begin
                    if ($urandom_range(0, 1) == 1) begin
                        d[j][i] = $urandom;
                    end else begin
                        sv = int'($urandom_range(0, 2097152)) - 1048576;
                        d[j][i] = 32'(sv);
                    end
                end
            end
            model(a, n, d, ev, es);
            run_column(a, n, d, 2, gv, gs, t_ok, r_ok, b_seen);
            checks++;
            if (gv !== ev || gs !== es) begin
                failures++;
                $display("FAIL rand_v it=%0d n=%0d got=%h sat=%b exp=%h sat=%b",
                         it, n, gv, gs, ev, es);
            end
            checks++;
            if (t_ok !== 1'b1 || r_ok !== 1'b1) begin
                failures++;
                $display("FAIL rand_timing it=%0d got t=%b r=%b exp 1 1",
                         it, t_ok, r_ok);
            end
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_back_to_back();
        test_zero_proj();
        test_saturation();
        test_extra();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
